// File: rtl/hit_range_resolver.sv
// Two-player squared-distance range check (3-stage pipeline) with per-player attack FSMs.
// Optional macro HIT_BLOCK_EN: a guarding victim turns a landed hit into a punished miss.
module hit_range_resolver #(
    parameter int COORD_W         = 7,
    parameter int COLLIDE_R       = 20,
    parameter int HIT_R           = 24,
    parameter int COOLDOWN_CYCLES = 16,
    parameter int CNT_W           = 8
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               sample_valid,
    input  logic [COORD_W-1:0] p1_x,
    input  logic [COORD_W-1:0] p1_y,
    input  logic [COORD_W-1:0] p2_x,
    input  logic [COORD_W-1:0] p2_y,
    input  logic               p1_attack,
    input  logic               p2_attack,
    input  logic               p1_block,
    input  logic               p2_block,
    output logic               result_valid,
    output logic               collision,
    output logic               in_range,
    output logic               p1_hit,
    output logic               p2_hit,
    output logic               p1_miss,
    output logic               p2_miss,
    output logic               p1_busy,
    output logic               p2_busy
);

    // state    | meaning
    // IDLE     | no attack pending
    // ARMED    | attack requested, waiting for the next distance result
    // COOLDOWN | hit landed (or was blocked), counting down before accepting attacks

    localparam int SQ_W  = 2 * COORD_W;
    localparam int SUM_W = 2 * COORD_W + 1;
    localparam logic [SUM_W-1:0] COLLIDE_SQ = SUM_W'(COLLIDE_R * COLLIDE_R);
    localparam logic [SUM_W-1:0] HIT_SQ     = SUM_W'(HIT_R * HIT_R);
    localparam logic [CNT_W-1:0] CNT_LOAD   = CNT_W'(COOLDOWN_CYCLES);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        ARMED    = 2'd1,
        COOLDOWN = 2'd2
    } state_t;

    function automatic logic [COORD_W-1:0] abs_diff(input logic [COORD_W-1:0] a,
                                                    input logic [COORD_W-1:0] b);
        return (a >= b) ? (a - b) : (b - a);
    endfunction

    logic               v1, v2;
    logic [COORD_W-1:0] dx_q, dy_q;
    logic [SQ_W-1:0]    dx2_q, dy2_q;
    logic [SUM_W-1:0]   sum;

    assign sum = {1'b0, dx2_q} + {1'b0, dy2_q};

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            v1           <= 1'b0;
            v2           <= 1'b0;
            dx_q         <= '0;
            dy_q         <= '0;
            dx2_q        <= '0;
            dy2_q        <= '0;
            result_valid <= 1'b0;
            collision    <= 1'b0;
            in_range     <= 1'b0;
        end else begin
            v1           <= sample_valid;
            v2           <= v1;
            result_valid <= v2;
            if (sample_valid) begin
                dx_q <= abs_diff(p1_x, p2_x);
                dy_q <= abs_diff(p1_y, p2_y);
            end
            if (v1) begin
                dx2_q <= SQ_W'(dx_q) * SQ_W'(dx_q);
                dy2_q <= SQ_W'(dy_q) * SQ_W'(dy_q);
            end
            if (v2) begin
                collision <= (sum < COLLIDE_SQ);
                in_range  <= (sum < HIT_SQ);
            end
        end
    end

    // index 0 is player 1, index 1 is player 2; victim_block[i] is the other player's guard
    logic [1:0]       attack, victim_block;
    state_t           state_q [2];
    state_t           state_d [2];
    logic [CNT_W-1:0] cnt_q [2];
    logic [CNT_W-1:0] cnt_d [2];
    logic [1:0]       hit_d, miss_d, hit_q, miss_q;

    assign attack = {p2_attack, p1_attack};

`ifdef HIT_BLOCK_EN
    assign victim_block = {p1_block, p2_block};
`else
    logic unused_block;
    assign unused_block = p1_block | p2_block;
    assign victim_block = 2'b00;
`endif

    always_comb begin
        for (int i = 0; i < 2; i++) begin
            state_d[i] = state_q[i];
            cnt_d[i]   = cnt_q[i];
            hit_d[i]   = 1'b0;
            miss_d[i]  = 1'b0;
            case (state_q[i])
                IDLE: begin
                    if (attack[i]) state_d[i] = ARMED;
                end
                ARMED: begin
                    if (result_valid) begin
                        if (in_range) begin
                            hit_d[i]   = ~victim_block[i];
                            miss_d[i]  = victim_block[i];
                            cnt_d[i]   = CNT_LOAD;
                            state_d[i] = COOLDOWN;
                        end else begin
                            miss_d[i]  = 1'b1;
                            state_d[i] = IDLE;
                        end
                    end
                end
                COOLDOWN: begin
                    // terminal count at 1 keeps COOLDOWN exactly CNT_LOAD cycles long
                    if (cnt_q[i] <= CNT_W'(1)) begin
                        cnt_d[i]   = '0;
                        state_d[i] = IDLE;
                    end else begin
                        cnt_d[i] = cnt_q[i] - CNT_W'(1);
                    end
                end
                default: begin
                    cnt_d[i]   = '0;
                    state_d[i] = IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < 2; i++) begin
                state_q[i] <= IDLE;
                cnt_q[i]   <= '0;
            end
            hit_q  <= 2'b00;
            miss_q <= 2'b00;
        end else begin
            for (int i = 0; i < 2; i++) begin
                state_q[i] <= state_d[i];
                cnt_q[i]   <= cnt_d[i];
            end
            hit_q  <= hit_d;
            miss_q <= miss_d;
        end
    end

    assign p1_hit  = hit_q[0];
    assign p2_hit  = hit_q[1];
    assign p1_miss = miss_q[0];
    assign p2_miss = miss_q[1];
    assign p1_busy = (state_q[0] != IDLE);
    assign p2_busy = (state_q[1] != IDLE);

endmodule

// File: tb/tb_hit_range_resolver.sv
// Directed bench for hit_range_resolver: distance table at full throughput plus
// hand sequences for hit, miss/re-arm, trade, block and mid-operation reset.
module tb_hit_range_resolver;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       sample_valid;
    logic [6:0] p1_x, p1_y, p2_x, p2_y;
    logic       p1_attack, p2_attack, p1_block, p2_block;
    logic       result_valid, collision, in_range;
    logic       p1_hit, p2_hit, p1_miss, p2_miss, p1_busy, p2_busy;

    int tests = 0;
    int fails = 0;
    int ev_p1_hit, ev_p1_miss, ev_p2_hit, ev_p2_miss;

    always #5 clk = ~clk;

    hit_range_resolver dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .sample_valid (sample_valid),
        .p1_x         (p1_x),
        .p1_y         (p1_y),
        .p2_x         (p2_x),
        .p2_y         (p2_y),
        .p1_attack    (p1_attack),
        .p2_attack    (p2_attack),
        .p1_block     (p1_block),
        .p2_block     (p2_block),
        .result_valid (result_valid),
        .collision    (collision),
        .in_range     (in_range),
        .p1_hit       (p1_hit),
        .p2_hit       (p2_hit),
        .p1_miss      (p1_miss),
        .p2_miss      (p2_miss),
        .p1_busy      (p1_busy),
        .p2_busy      (p2_busy)
    );

    typedef struct {
        logic [6:0] ax, ay, bx, by;
        logic       coll, inr;
    } vec_t;

    vec_t vecs [11];

    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        ev_p1_hit  += int'(p1_hit);
        ev_p1_miss += int'(p1_miss);
        ev_p2_hit  += int'(p2_hit);
        ev_p2_miss += int'(p2_miss);
    endtask

    task automatic clear_ev();
        ev_p1_hit  = 0;
        ev_p1_miss = 0;
        ev_p2_hit  = 0;
        ev_p2_miss = 0;
    endtask

    task automatic set_pos(input int ax, input int ay, input int bx, input int by);
        p1_x = 7'(ax);
        p1_y = 7'(ay);
        p2_x = 7'(bx);
        p2_y = 7'(by);
    endtask

    function automatic int all_outs();
        return int'({result_valid, collision, in_range, p1_hit, p2_hit,
                     p1_miss, p2_miss, p1_busy, p2_busy});
    endfunction

    initial begin
        int k;
        int n;
        logic exp_blk_hit, exp_blk_miss;

        // d^2 thresholds: collision below 400, in range below 576
        vecs[0]  = '{7'd10,  7'd10,  7'd30,  7'd10,  1'b0, 1'b1};  // 400
        vecs[1]  = '{7'd10,  7'd10,  7'd29,  7'd10,  1'b1, 1'b1};  // 361
        vecs[2]  = '{7'd0,   7'd0,   7'd127, 7'd127, 1'b0, 1'b0};  // 32258
        vecs[3]  = '{7'd10,  7'd10,  7'd34,  7'd10,  1'b0, 1'b0};  // 576
        vecs[4]  = '{7'd10,  7'd10,  7'd33,  7'd10,  1'b0, 1'b1};  // 529
        vecs[5]  = '{7'd30,  7'd10,  7'd10,  7'd10,  1'b0, 1'b1};  // 400 reversed
        vecs[6]  = '{7'd50,  7'd50,  7'd50,  7'd50,  1'b1, 1'b1};  // 0
        vecs[7]  = '{7'd100, 7'd40,  7'd88,  7'd56,  1'b0, 1'b1};  // 144+256
        vecs[8]  = '{7'd5,   7'd5,   7'd17,  7'd21,  1'b0, 1'b1};  // 144+256
        vecs[9]  = '{7'd127, 7'd0,   7'd0,   7'd127, 1'b0, 1'b0};  // 32258
        vecs[10] = '{7'd60,  7'd60,  7'd72,  7'd75,  1'b1, 1'b1};  // 144+225

        clear_ev();
        reset_n = 1'b0;
        p1_block = 1'b0;
        p2_block = 1'b0;
        set_pos(10, 10, 12, 10);
        sample_valid = 1'b1;
        p1_attack = 1'b1;
        p2_attack = 1'b1;
        #1;
        for (int i = 0; i < 4; i++) begin
            step();
            check("reset_outputs_zero", all_outs(), 0);
        end
        sample_valid = 1'b0;
        p1_attack = 1'b0;
        p2_attack = 1'b0;
        step();
        reset_n = 1'b1;
        step();

        // distance table, one sample per cycle; result for vector c appears 3 cycles later
        for (int c = 0; c < 14; c++) begin
            if (c < 3) begin
                check("first_result_latency", int'(result_valid), 0);
            end else begin
                check("table_valid", int'(result_valid), 1);
                check($sformatf("table_collision[%0d]", c - 3), int'(collision), int'(vecs[c-3].coll));
                check($sformatf("table_in_range[%0d]", c - 3), int'(in_range), int'(vecs[c-3].inr));
            end
            if (c < 11) begin
                set_pos(int'(vecs[c].ax), int'(vecs[c].ay), int'(vecs[c].bx), int'(vecs[c].by));
                sample_valid = 1'b1;
            end else begin
                sample_valid = 1'b0;
            end
            step();
        end
        check("valid_drops_after_burst", int'(result_valid), 0);
        check("collision_holds", int'(collision), int'(vecs[10].coll));
        check("no_events_without_attack", ev_p1_hit + ev_p1_miss + ev_p2_hit + ev_p2_miss, 0);

        // hit with cooldown; attack during cooldown must be ignored
        repeat (3) step();
        clear_ev();
        set_pos(10, 10, 30, 10);
        p1_attack = 1'b1;
        sample_valid = 1'b1;
        step();
        p1_attack = 1'b0;
        sample_valid = 1'b0;
        k = 1;
        while (!p1_hit && k < 12) begin
            step();
            k++;
        end
        check("hit_latency_cycles", k, 4);
        n = 0;
        while (p1_busy && n < 40) begin
            p1_attack    = (n == 3);
            sample_valid = (n == 3);
            step();
            n++;
        end
        p1_attack = 1'b0;
        sample_valid = 1'b0;
        check("cooldown_busy_cycles", n, 16);
        repeat (8) step();
        check("hit_count", ev_p1_hit, 1);
        check("hit_no_miss", ev_p1_miss, 0);
        check("hit_p2_quiet", ev_p2_hit + ev_p2_miss, 0);
        check("cooldown_attack_ignored", int'(p1_busy), 0);

        // miss at extreme distance, attack held high re-arms
        clear_ev();
        set_pos(0, 0, 127, 127);
        p2_attack = 1'b1;
        sample_valid = 1'b1;
        step();
        sample_valid = 1'b0;
        step();
        step();
        check("miss_armed_busy", int'(p2_busy), 1);
        step();
        check("miss_pulse", int'(p2_miss), 1);
        check("miss_no_hit", int'(p2_hit), 0);
        check("miss_busy_dropped", int'(p2_busy), 0);
        check("miss_extreme_in_range", int'(in_range), 0);
        step();
        check("rearm_busy", int'(p2_busy), 1);
        p2_attack = 1'b0;
        sample_valid = 1'b1;
        step();
        sample_valid = 1'b0;
        repeat (6) step();
        check("rearm_miss_count", ev_p2_miss, 2);
        check("rearm_hit_count", ev_p2_hit, 0);
        check("rearm_idle", int'(p2_busy), 0);

        // trade: both attack at distance 10
        clear_ev();
        set_pos(40, 40, 50, 40);
        p1_attack = 1'b1;
        p2_attack = 1'b1;
        sample_valid = 1'b1;
        step();
        p1_attack = 1'b0;
        p2_attack = 1'b0;
        sample_valid = 1'b0;
        repeat (3) step();
        check("trade_p1_hit", int'(p1_hit), 1);
        check("trade_p2_hit", int'(p2_hit), 1);
        repeat (20) step();
        check("trade_idle", int'({p1_busy, p2_busy}), 0);
        check("trade_event_total", ev_p1_hit + ev_p2_hit + ev_p1_miss + ev_p2_miss, 2);

        // victim guarding while p1 is in range
`ifdef HIT_BLOCK_EN
        exp_blk_hit  = 1'b0;
        exp_blk_miss = 1'b1;
`else
        exp_blk_hit  = 1'b1;
        exp_blk_miss = 1'b0;
`endif
        clear_ev();
        set_pos(10, 10, 30, 10);
        p2_block = 1'b1;
        p1_attack = 1'b1;
        sample_valid = 1'b1;
        step();
        p1_attack = 1'b0;
        sample_valid = 1'b0;
        repeat (3) step();
        check("block_hit", int'(p1_hit), int'(exp_blk_hit));
        check("block_miss", int'(p1_miss), int'(exp_blk_miss));
        check("block_enters_cooldown", int'(p1_busy), 1);
        p2_block = 1'b0;
        repeat (20) step();
        check("block_idle", int'(p1_busy), 0);

        // reset mid-operation aborts the pending attack silently
        clear_ev();
        p1_attack = 1'b1;
        sample_valid = 1'b1;
        step();
        p1_attack = 1'b0;
        sample_valid = 1'b0;
        step();
        reset_n = 1'b0;
        #1;
        check("midreset_outputs_zero", all_outs(), 0);
        step();
        reset_n = 1'b1;
        repeat (8) step();
        check("midreset_no_events", ev_p1_hit + ev_p1_miss, 0);
        check("midreset_idle", int'({p1_busy, result_valid}), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
